// File: rtl/norm_pipe.sv
// norm_pipe: two-stage leading-zero-count and normalise unit for the FMA datapath.
// Sits between the adder and the rounder. Stage 1 counts leading zeros of the
// incoming significand; stage 2 left-justifies it, adjusts the exponent and
// raises the zero / subnormal-clamp / overflow flags.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   in_valid / in_ready    input handshake (in_ready depends only on pipeline
//                          state and out_ready, never on in_valid)
//   in_sm, in_se           unnormalised significand, biased unsigned exponent
//   out_valid / out_ready  output handshake
//   out_sm, out_se         normalised significand, adjusted exponent
//   out_zcnt               leading-zero count of the input (WIDTH when zero)
//   out_zero               input significand was all zeros
//   out_denorm             shift was clamped to keep the exponent at EMIN
//   out_ovf                adjusted exponent exceeded 2^EXP_WIDTH-1
module norm_pipe #(
  parameter int WIDTH      = 34,
  parameter int EXP_WIDTH  = 7,
  parameter int EXP_ADJ    = 11,
  parameter int EMIN       = 1,
  parameter bit SUBNORM_EN = 1'b1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sm,
  input  logic [EXP_WIDTH-1:0] in_se,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sm,
  output logic [EXP_WIDTH-1:0] out_se,
  output logic [CW-1:0]        out_zcnt,
  output logic                 out_zero,
  output logic                 out_denorm,
  output logic                 out_ovf
);

  // Signed working width for exponent arithmetic.
  localparam int unsigned RW = EXP_WIDTH + 2;

  localparam logic signed [RW-1:0] ADJ_S    = $signed(RW'(EXP_ADJ));
  localparam logic signed [RW-1:0] EMIN_S   = $signed(RW'(EMIN));
  localparam logic signed [RW-1:0] SE_MAX_S = $signed(RW'((2 ** EXP_WIDTH) - 1));

  // Leading zeros from the MSB; WIDTH when the operand is zero.
  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) cnt = CW'(WIDTH - 1 - i);
    end
    return cnt;
  endfunction

  // Stage 1 registers.
  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_sm;
  logic [EXP_WIDTH-1:0] s1_se;
  logic [CW-1:0]        s1_zcnt;
  logic                 s1_zero;

  // Handshake: a stage advances when its downstream slot is free or draining.
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 2 next-state values.
  logic signed [RW-1:0] raw;
  logic signed [RW-1:0] sub_room;
  logic [CW-1:0]        shift;
  logic [WIDTH-1:0]     nxt_sm;
  logic [EXP_WIDTH-1:0] nxt_se;
  logic                 nxt_denorm;
  logic                 nxt_ovf;

  // Exponent adjust, shift selection and flags for the beat held in stage 1.
  always_comb begin
    raw        = $signed({2'b00, s1_se}) - $signed(RW'(s1_zcnt)) + ADJ_S;
    // Largest shift that keeps the exponent at EMIN; negative means none.
    sub_room   = $signed({2'b00, s1_se}) + ADJ_S - EMIN_S;
    shift      = '0;
    nxt_sm     = '0;
    nxt_se     = '0;
    nxt_denorm = 1'b0;
    nxt_ovf    = 1'b0;
    if (s1_zero) begin
      // Zero operand: everything stays cleared.
      nxt_sm = '0;
    end else if (SUBNORM_EN && (raw < EMIN_S)) begin
      shift      = sub_room[RW-1] ? '0 : CW'(sub_room);
      nxt_sm     = s1_sm << shift;
      nxt_se     = '0;
      nxt_denorm = 1'b1;
    end else begin
      // Without clamping a negative raw simply wraps into out_se.
      shift   = s1_zcnt;
      nxt_sm  = s1_sm << shift;
      nxt_se  = raw[EXP_WIDTH-1:0];
      nxt_ovf = (raw > SE_MAX_S);
    end
  end

  // Stage 1: capture operand and its leading-zero count on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sm    <= '0;
      s1_se    <= '0;
      s1_zcnt  <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sm   <= in_sm;
        s1_se   <= in_se;
        s1_zcnt <= lzc(in_sm);
        s1_zero <= (in_sm == '0);
      end
    end
  end

  // Stage 2: registered results; held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_sm     <= '0;
      out_se     <= '0;
      out_zcnt   <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sm     <= nxt_sm;
        out_se     <= nxt_se;
        out_zcnt   <= s1_zcnt;
        out_zero   <= s1_zero;
        out_denorm <= nxt_denorm;
        out_ovf    <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_norm_pipe.sv
// Bench for norm_pipe with default parameters (WIDTH=34, EXP_WIDTH=7,
// EXP_ADJ=11, EMIN=1, SUBNORM_EN=1).
module tb_norm_pipe;

  localparam int W    = 34;
  localparam int EW   = 7;
  localparam int ZW   = 6;
  localparam int ADJ  = 11;
  localparam int EMIN = 1;

  typedef struct packed {
    logic [W-1:0]  sm;
    logic [EW-1:0] se;
    logic [ZW-1:0] zcnt;
    logic          zero;
    logic          denorm;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sm;
  logic [EW-1:0] in_se;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sm;
  logic [EW-1:0] out_se;
  logic [ZW-1:0] out_zcnt;
  logic          out_zero;
  logic          out_denorm;
  logic          out_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  norm_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sm     (in_sm),
    .in_se     (in_se),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sm    (out_sm),
    .out_se    (out_se),
    .out_zcnt  (out_zcnt),
    .out_zero  (out_zero),
    .out_denorm(out_denorm),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: normalise with integer arithmetic straight from the rules.
  function automatic res_t model(input logic [W-1:0] sm, input logic [EW-1:0] se);
    res_t r;
    logic [W-1:0] t;
    int lz;
    int raw;
    int sh;
    r  = '0;
    t  = sm;
    lz = 0;
    if (sm == '0) lz = W;
    else while (!t[W-1]) begin t = t << 1; lz++; end
    r.zcnt = ZW'(lz);
    if (sm == '0) begin
      r.zero = 1'b1;
      return r;
    end
    raw = int'(se) - lz + ADJ;
    if (raw < EMIN) begin
      sh = int'(se) + ADJ - EMIN;
      if (sh < 0) sh = 0;
      r.sm     = sm << sh;
      r.denorm = 1'b1;
    end else begin
      r.sm  = sm << lz;
      r.se  = EW'(raw);
      r.ovf = (raw > (2 ** EW) - 1);
    end
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.sm = out_sm; r.se = out_se; r.zcnt = out_zcnt;
    r.zero = out_zero; r.denorm = out_denorm; r.ovf = out_ovf;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_sm();
    logic [W-1:0] v;
    v = W'({$urandom, $urandom});
    if ($urandom_range(0, 15) == 0) v = '0;
    else v = v >> $urandom_range(0, W - 1);
    return v;
  endfunction

  function automatic logic [EW-1:0] rand_se();
    if ($urandom_range(0, 1) == 0) return EW'($urandom_range(0, 15));
    return EW'($urandom_range(0, 127));
  endfunction

  // Drive one beat with no backpressure; return the result and accept-to-valid latency.
  task automatic run_one(input logic [W-1:0] sm, input logic [EW-1:0] se,
                         output res_t got, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_sm = sm; in_se = se; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      #1;
    end
    got = sample();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_sm = '0; in_se = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_checks++;
    if (sample() !== res_t'(0)) $display("FAIL reset_outputs got=%h exp=0", sample());
    else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    res_t got;
    res_t exp;
    int lat;
    // Basic normalise.
    run_one(W'(1) << 22, 7'd15, got, lat);
    exp = '{sm: 34'h2_0000_0000, se: 7'd15, zcnt: 6'd11, zero: 1'b0, denorm: 1'b0, ovf: 1'b0};
    n_checks++;
    if (got !== exp) $display("FAIL basic_result got=%h exp=%h", got, exp);
    else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL basic_latency got=%0d exp=2", lat);
    else n_pass++;
    // Zero input.
    run_one('0, 7'd40, got, lat);
    exp = '{sm: '0, se: 7'd0, zcnt: 6'd34, zero: 1'b1, denorm: 1'b0, ovf: 1'b0};
    n_checks++;
    if (got !== exp) $display("FAIL zero_result got=%h exp=%h", got, exp);
    else n_pass++;
    // Subnormal clamp.
    run_one(W'(1) << 10, 7'd2, got, lat);
    exp = '{sm: W'(1) << 22, se: 7'd0, zcnt: 6'd23, zero: 1'b0, denorm: 1'b1, ovf: 1'b0};
    n_checks++;
    if (got !== exp) $display("FAIL subnorm_result got=%h exp=%h", got, exp);
    else n_pass++;
    // Overflow.
    run_one(W'(1) << 33, 7'd120, got, lat);
    exp = '{sm: W'(1) << 33, se: 7'd3, zcnt: 6'd0, zero: 1'b0, denorm: 1'b0, ovf: 1'b1};
    n_checks++;
    if (got !== exp) $display("FAIL ovf_result got=%h exp=%h", got, exp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sa, sb, sc;
    logic [EW-1:0] ea_se, eb_se, ec_se;
    res_t ea, eb, ec, got;
    sa = rand_sm() | W'(1); sb = rand_sm() | W'(2); sc = rand_sm() | W'(4);
    ea_se = rand_se(); eb_se = rand_se(); ec_se = rand_se();
    ea = model(sa, ea_se); eb = model(sb, eb_se); ec = model(sc, ec_se);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_sm = sa; in_se = ea_se;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_accept_a got=%b exp=1", in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    in_sm = sb; in_se = eb_se;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_accept_b got=%b exp=1", in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    in_sm = sc; in_se = ec_se;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", in_ready);
    else n_pass++;
    got = sample();
    n_checks++;
    if (!out_valid || got !== ea) $display("FAIL bp_head got=%b/%h exp=1/%h", out_valid, got, ea);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    got = sample();
    n_checks++;
    if (!out_valid || in_ready || got !== ea)
      $display("FAIL bp_hold got=%b/%b/%h exp=1/0/%h", out_valid, in_ready, got, ea);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (!out_valid || got !== eb) $display("FAIL bp_second got=%b/%h exp=1/%h", out_valid, got, eb);
    else n_pass++;
    @(posedge clk);
    @(negedge clk); #1;
    got = sample();
    n_checks++;
    if (!out_valid || got !== ec) $display("FAIL bp_third got=%b/%h exp=1/%h", out_valid, got, ec);
    else n_pass++;
    @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    res_t got;
    res_t exp;
    int lat;
    int stale;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_sm = rand_sm(); in_se = rand_se();
    @(posedge clk);
    @(negedge clk);
    in_sm = rand_sm(); in_se = rand_se();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rst_pre_full got=%b/%b exp=1/0", out_valid, in_ready);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sample() !== res_t'(0))
      $display("FAIL rst_async got=%b/%h exp=0/0", out_valid, sample());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) $display("FAIL rst_stale got=%0d exp=0", stale);
    else n_pass++;
    in_sm = rand_sm() | W'(1 << 5);
    in_se = rand_se();
    exp = model(in_sm, in_se);
    run_one(in_sm, in_se, got, lat);
    n_checks++;
    if (got !== exp || lat !== 2)
      $display("FAIL rst_fresh got=%h/%0d exp=%h/2", got, lat, exp);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    res_t q[$];
    res_t got;
    res_t exp;
    int drain;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sm     = rand_sm();
      in_se     = rand_se();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got = sample();
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_unexpected got=%h exp=none", got);
        else begin
          exp = q.pop_front();
          if (got !== exp) $display("FAIL rand_beat got=%h exp=%h", got, exp);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_sm, in_se));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    drain = 0;
    #1;
    while (q.size() != 0 && drain < 20) begin
      if (out_valid) begin
        got = sample();
        exp = q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL rand_drain got=%h exp=%h", got, exp);
        else n_pass++;
      end
      @(negedge clk); #1;
      drain++;
    end
    n_checks++;
    if (q.size() != 0 || out_valid)
      $display("FAIL rand_leftover got=%0d/%b exp=0/0", q.size(), out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
